// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier: sequencer states, step op codes, default width.
package mult_pkg;

   localparam int MP_NUM_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      ARITH = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2
   } op_t;

endpackage

// File: rtl/mult_step_decode.sv
// Per-step arithmetic decision from the multiplier LSB, Booth guard bit and final-step flag.
// Optional feature macro: BOOTH_EN selects radix-2 Booth recoding instead of plain signed shift-add.
module mult_step_decode
   import mult_pkg::*;
(
   input  logic q0,
   input  logic qm1,
   input  logic last,
   output op_t  op
);

`ifdef BOOTH_EN
   // Booth recoding never needs to know which step is the last one
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      op = OP_NONE;
      case ({q0, qm1})
         2'b10:   op = OP_SUB;
         2'b01:   op = OP_ADD;
         default: op = OP_NONE;
      endcase
   end
`else
   logic unused_qm1;
   assign unused_qm1 = qm1;

   // The multiplier MSB carries negative weight, so its partial product is subtracted
   always_comb begin
      op = OP_NONE;
      if (q0) begin
         op = last ? OP_SUB : OP_ADD;
      end
   end
`endif

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer FSM for the signed shift-add multiplier; drives datapath strobes and the step-counter enable.
// Optional feature macro: BOOTH_EN (handled inside mult_step_decode).
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int MP_NUM = MP_NUM_DEFAULT
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic q0_i,
   input  logic qm1_i,
   input  logic k_i,
   output logic load_o,
   output logic add_o,
   output logic sub_o,
   output logic shift_o,
   output logic cnt_o,
   output logic busy_o,
   output logic done_o
);

   if (MP_NUM < 2) begin : g_mp_num_check
      $error("mult_seq_ctrl: MP_NUM must be at least 2");
   end

   state_t state, state_nxt;
   op_t    op_q, op_nxt, step_op;
   logic   last_q, last_nxt;
   logic   last_eval;

   // k_i is only a one-cycle pulse, so the final-step flag is held in last_q once seen
   assign last_eval = last_q | k_i;

   mult_step_decode u_step_decode (
      .q0   (q0_i),
      .qm1  (qm1_i),
      .last (last_eval),
      .op   (step_op)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= OP_NONE;
         last_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         op_q   <= op_nxt;
         last_q <= last_nxt;
      end
   end

   // Next-state logic with Moore outputs decoded from the registered state and op choice
   always_comb begin
      state_nxt = state;
      op_nxt    = op_q;
      last_nxt  = last_q;
      load_o    = 1'b0;
      add_o     = 1'b0;
      sub_o     = 1'b0;
      shift_o   = 1'b0;
      cnt_o     = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            load_o    = 1'b1;
            busy_o    = 1'b1;
            last_nxt  = 1'b0;
            state_nxt = EVAL;
         end
         EVAL: begin
            busy_o    = 1'b1;
            last_nxt  = last_eval;
            op_nxt    = step_op;
            state_nxt = (step_op == OP_NONE) ? SHIFT : ARITH;
         end
         ARITH: begin
            busy_o    = 1'b1;
            add_o     = (op_q == OP_ADD);
            sub_o     = (op_q == OP_SUB);
            state_nxt = SHIFT;
         end
         SHIFT: begin
            busy_o    = 1'b1;
            shift_o   = 1'b1;
            cnt_o     = 1'b1;
            state_nxt = last_q ? DONE : EVAL;
         end
         DONE: begin
            busy_o    = 1'b1;
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
